// File: rtl/write_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// write_ptr_full_ctrl
//
// Write-side pointer and status controller for an asynchronous FIFO.
// It holds the binary write pointer and its Gray copy for the clock-domain
// crossing. From the read pointer, which has already been synchronised into
// the write domain, it works out full, almost-full and free-entry status.
//
// Parameters
//   ADDR_WIDTH    FIFO address bits, DEPTH = 2**ADDR_WIDTH (>= 2)
//   AFULL_THRESH  almost-full level in free entries (0..DEPTH-1)
//
// Ports
//   w_clk_in            in   write-domain clock (rising edge)
//   w_reset_n_in        in   asynchronous active-low reset
//   w_request_in        in   write request from the producer
//   r_ptr_gray_sync_in  in   Gray read pointer, synchronised to w_clk_in
//   overflow_clr_in     in   clears the sticky overflow flag
//   w_en_out            out  RAM write strobe (request & not full)
//   w_addr_out          out  binary RAM write address
//   w_ptr_gray_out      out  registered Gray write pointer
//   full_out            out  FIFO full (registered)
//   almost_full_out     out  free entries <= AFULL_THRESH (registered)
//   free_count_out      out  free entries 0..DEPTH (registered)
//   overflow_out        out  sticky write-while-full flag
//
// Configuration
//   WFIFO_OVERFLOW_STICKY_EN  defined: overflow_out is a sticky flag that
//                             overflow_clr_in clears.
//                             undefined: overflow_out is held at 0 and
//                             overflow_clr_in has no effect.
// -----------------------------------------------------------------------------
module write_ptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  w_clk_in,
  input  logic                  w_reset_n_in,
  input  logic                  w_request_in,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray_sync_in,
  input  logic                  overflow_clr_in,
  output logic                  w_en_out,
  output logic [ADDR_WIDTH-1:0] w_addr_out,
  output logic [ADDR_WIDTH:0]   w_ptr_gray_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   free_count_out,
  output logic                  overflow_out
);

  // DEPTH expressed in pointer width: a single one in the MSB position.
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C   = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Gray code helpers
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] gray);
    logic [ADDR_WIDTH:0] bin;
    bin[ADDR_WIDTH] = gray[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH:0] bin_r;
  logic [ADDR_WIDTH:0] gray_r;
  logic                full_r;
  logic                afull_r;
  logic [ADDR_WIDTH:0] free_r;
  logic                ovf_r;

  // ---------------------------------------------------------------------------
  // Next-state terms
  // ---------------------------------------------------------------------------
  logic                accept_s;
  logic [ADDR_WIDTH:0] bin_next_s;
  logic [ADDR_WIDTH:0] gray_next_s;
  logic [ADDR_WIDTH:0] r_bin_s;
  logic [ADDR_WIDTH:0] r_gray_full_s;
  logic [ADDR_WIDTH:0] used_next_s;
  logic [ADDR_WIDTH:0] free_next_s;
  logic                full_next_s;
  logic                afull_next_s;

  // Accept, next pointer, and full/free status evaluated against the read pointer
  always_comb begin
    accept_s      = 1'b0;
    bin_next_s    = bin_r;
    gray_next_s   = gray_r;
    r_bin_s       = '0;
    r_gray_full_s = '0;
    used_next_s   = '0;
    free_next_s   = DEPTH_C;
    full_next_s   = 1'b0;
    afull_next_s  = 1'b0;

    // A request seen while full_out is high is dropped. The registered flag
    // keeps rejecting for one cycle after a read frees space.
    accept_s = w_request_in & ~full_r;

    if (accept_s) begin
      bin_next_s = bin_r + PTR_ONE_C;
    end else begin
      bin_next_s = bin_r;
    end

    gray_next_s = bin2gray(bin_next_s);
    r_bin_s     = gray2bin(r_ptr_gray_sync_in);

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that means the two MSBs differ and the rest match.
    r_gray_full_s = {~r_ptr_gray_sync_in[ADDR_WIDTH:ADDR_WIDTH-1],
                     r_ptr_gray_sync_in[ADDR_WIDTH-2:0]};
    full_next_s   = (gray_next_s == r_gray_full_s);

    // The subtraction wraps modulo 2**(ADDR_WIDTH+1), so the count stays
    // correct when either pointer rolls over.
    used_next_s  = bin_next_s - r_bin_s;
    free_next_s  = DEPTH_C - used_next_s;
    afull_next_s = (free_next_s <= AFULL_C);
  end

  // Pointer and status registers
  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      bin_r   <= '0;
      gray_r  <= '0;
      full_r  <= 1'b0;
      afull_r <= 1'b0;
      free_r  <= DEPTH_C;
    end else begin
      bin_r   <= bin_next_s;
      gray_r  <= gray_next_s;
      full_r  <= full_next_s;
      afull_r <= afull_next_s;
      free_r  <= free_next_s;
    end
  end

`ifdef WFIFO_OVERFLOW_STICKY_EN
  // Sticky overflow: setting has priority over clearing
  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      ovf_r <= 1'b0;
    end else if (w_request_in && full_r) begin
      ovf_r <= 1'b1;
    end else if (overflow_clr_in) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end
`else
  // Overflow tracking disabled: flag leaves reset at 0 and can never set
  always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
    if (!w_reset_n_in) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r & ~overflow_clr_in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_en_out        = accept_s;
  assign w_addr_out      = bin_r[ADDR_WIDTH-1:0];
  assign w_ptr_gray_out  = gray_r;
  assign full_out        = full_r;
  assign almost_full_out = afull_r;
  assign free_count_out  = free_r;
  assign overflow_out    = ovf_r;

endmodule
